// File: rtl/sram_pkg.sv
// Shared SRAM port widths, responder state encoding and the read-path fault helper.
package sram_pkg;

    localparam int SRAM_ADDR_WIDTH = 18;
    localparam int SRAM_DATA_WIDTH = 16;

    typedef enum logic {
        S_READY,
        S_INIT
    } responder_state_t;

    // Source of the word held in read stage 1
    typedef enum logic [1:0] {
        SEL_ZERO,
        SEL_RAM,
        SEL_WDATA,
        SEL_INIT
    } stage_sel_t;

    function automatic logic [SRAM_DATA_WIDTH-1:0] apply_fault(
        input logic [SRAM_DATA_WIDTH-1:0] data,
        input logic                       hit,
        input logic [3:0]                 bit_index,
        input logic                       value
    );
        logic [SRAM_DATA_WIDTH-1:0] result;
        result = data;
        if (hit) begin
            result[bit_index] = value;
        end
        return result;
    endfunction

endpackage

// File: rtl/sram_responder_mem.sv
// Single-port synchronous RAM with registered read and no reset, written to infer block RAM.
module sram_responder_mem #(
    parameter int DEPTH      = 1024,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int DATA_WIDTH = 16
) (
    input  logic                  Clock,
    input  logic                  write_enable,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic [DATA_WIDTH-1:0] read_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge Clock) begin
        if (write_enable) begin
            mem[address] <= write_data;
        end
        read_data <= mem[address];
    end

endmodule

// File: rtl/sram_responder.sv
// On-chip SRAM responder: two-cycle read latency, fill engine, stuck-at fault injector and access counters.
module sram_responder
    import sram_pkg::*;
#(
    parameter int                         DEPTH      = 1024,
    parameter logic [SRAM_DATA_WIDTH-1:0] INIT_VALUE = 16'h0000
) (
    input  logic                       Clock,
    input  logic                       Resetn,
    input  logic [SRAM_ADDR_WIDTH-1:0] SRAM_address,
    input  logic [SRAM_DATA_WIDTH-1:0] SRAM_write_data,
    input  logic                       SRAM_we_n,
    output logic [SRAM_DATA_WIDTH-1:0] SRAM_read_data,
    input  logic                       Init_start,
    output logic                       Init_busy,
    input  logic                       Fault_enable,
    input  logic [SRAM_ADDR_WIDTH-1:0] Fault_address,
    input  logic [3:0]                 Fault_bit,
    input  logic                       Fault_value,
    output logic                       Out_of_range,
    output logic [18:0]                Write_count,
    output logic [18:0]                Read_count
);

    localparam int                     AW        = $clog2(DEPTH);
    localparam logic [SRAM_ADDR_WIDTH:0] DEPTH_EXT = (SRAM_ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [AW-1:0]          FILL_LAST = AW'(DEPTH - 1);

    responder_state_t           state;
    responder_state_t           state_next;
    logic                       init_start_buf;
    logic [AW-1:0]              fill_addr;

    logic                       in_range;
    logic                       port_write;
    logic                       port_read;
    logic                       ram_we;
    logic [AW-1:0]              ram_addr;
    logic [SRAM_DATA_WIDTH-1:0] ram_wdata;
    logic [SRAM_DATA_WIDTH-1:0] ram_read_data;

    stage_sel_t                 s1_sel;
    stage_sel_t                 s1_sel_next;
    logic [SRAM_DATA_WIDTH-1:0] s1_write_data;
    logic                       s1_fault_hit;
    logic [3:0]                 s1_fault_bit;
    logic                       s1_fault_value;
    logic [SRAM_DATA_WIDTH-1:0] stage1_data;

    assign in_range   = {1'b0, SRAM_address} < DEPTH_EXT;
    assign port_write = (state == S_READY) && !SRAM_we_n;
    assign port_read  = (state == S_READY) && SRAM_we_n;
    assign Init_busy  = (state == S_INIT);

    // Next state, RAM port arbitration between fill engine and SRAM port, stage-1 source select
    always_comb begin
        state_next  = state;
        ram_we      = 1'b0;
        ram_addr    = SRAM_address[AW-1:0];
        ram_wdata   = SRAM_write_data;
        s1_sel_next = SEL_ZERO;
        case (state)
            S_READY: begin
                if (Init_start && !init_start_buf) begin
                    state_next = S_INIT;
                end
                ram_we = port_write && in_range;
                if (!SRAM_we_n) begin
                    s1_sel_next = SEL_WDATA;
                end else if (in_range) begin
                    s1_sel_next = SEL_RAM;
                end
            end
            S_INIT: begin
                ram_we      = 1'b1;
                ram_addr    = fill_addr;
                ram_wdata   = INIT_VALUE;
                s1_sel_next = SEL_INIT;
                if (fill_addr == FILL_LAST) begin
                    state_next = S_READY;
                end
            end
            default: state_next = S_READY;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state          <= S_READY;
            init_start_buf <= 1'b0;
            fill_addr      <= '0;
        end else begin
            state          <= state_next;
            init_start_buf <= Init_start;
            fill_addr      <= (state == S_INIT) ? fill_addr + 1'b1 : '0;
        end
    end

    sram_responder_mem #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (SRAM_DATA_WIDTH)
    ) u_mem (
        .Clock        (Clock),
        .write_enable (ram_we),
        .address      (ram_addr),
        .write_data   (ram_wdata),
        .read_data    (ram_read_data)
    );

    // Stage-1 side information travels alongside the registered RAM output
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            s1_sel <= SEL_ZERO;
        end else begin
            s1_sel <= s1_sel_next;
        end
        s1_write_data  <= SRAM_write_data;
        s1_fault_hit   <= Fault_enable && port_read && (SRAM_address == Fault_address);
        s1_fault_bit   <= Fault_bit;
        s1_fault_value <= Fault_value;
    end

    always_comb begin
        stage1_data = '0;
        case (s1_sel)
            SEL_RAM:   stage1_data = apply_fault(ram_read_data, s1_fault_hit, s1_fault_bit, s1_fault_value);
            SEL_WDATA: stage1_data = s1_write_data;
            SEL_INIT:  stage1_data = INIT_VALUE;
            default:   stage1_data = '0;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            SRAM_read_data <= '0;
            Out_of_range   <= 1'b0;
            Write_count    <= '0;
            Read_count     <= '0;
        end else begin
            SRAM_read_data <= stage1_data;
            if ((port_write || port_read) && !in_range) begin
                Out_of_range <= 1'b1;
            end
            if (port_write && (Write_count != 19'h7FFFF)) begin
                Write_count <= Write_count + 19'd1;
            end
            if (port_read && (Read_count != 19'h7FFFF)) begin
                Read_count <= Read_count + 19'd1;
            end
        end
    end

endmodule

// File: tb/tb_sram_responder.sv
// Directed bench for sram_responder: readback, fault injection, write-through, out-of-range, fill and reset mid-fill.
module tb_sram_responder;

    logic        Clock;
    logic        Resetn;
    logic [17:0] SRAM_address;
    logic [15:0] SRAM_write_data;
    logic        SRAM_we_n;
    logic [15:0] SRAM_read_data;
    logic        Init_start;
    logic        Init_busy;
    logic        Fault_enable;
    logic [17:0] Fault_address;
    logic [3:0]  Fault_bit;
    logic        Fault_value;
    logic        Out_of_range;
    logic [18:0] Write_count;
    logic [18:0] Read_count;

    int checkCount   = 0;
    int errorCount   = 0;
    int expWrites    = 0;
    int expReads     = 0;
    int busyCount    = 0;
    bit modelFilling = 1'b0;

    sram_responder #(
        .DEPTH      (1024),
        .INIT_VALUE (16'hA5A5)
    ) dut (
        .Clock           (Clock),
        .Resetn          (Resetn),
        .SRAM_address    (SRAM_address),
        .SRAM_write_data (SRAM_write_data),
        .SRAM_we_n       (SRAM_we_n),
        .SRAM_read_data  (SRAM_read_data),
        .Init_start      (Init_start),
        .Init_busy       (Init_busy),
        .Fault_enable    (Fault_enable),
        .Fault_address   (Fault_address),
        .Fault_bit       (Fault_bit),
        .Fault_value     (Fault_value),
        .Out_of_range    (Out_of_range),
        .Write_count     (Write_count),
        .Read_count      (Read_count)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Drives one access cycle; accesses outside a fill are counted by the bench model
    task automatic applyStimulus(input logic [17:0] addr, input logic [15:0] wdata, input logic weN);
        SRAM_address    = addr;
        SRAM_write_data = wdata;
        SRAM_we_n       = weN;
        if (!modelFilling) begin
            if (weN) expReads++;
            else     expWrites++;
        end
        @(posedge Clock);
        #1;
    endtask

    task automatic doReset();
        Resetn          = 1'b0;
        SRAM_address    = '0;
        SRAM_write_data = '0;
        SRAM_we_n       = 1'b1;
        @(posedge Clock);
        #1;
        Resetn    = 1'b1;
        expWrites = 0;
        expReads  = 0;
    endtask

    task automatic checkCounters(input string tag);
        checkOutput({tag, "_wcount"}, 32'(Write_count), 32'(expWrites));
        checkOutput({tag, "_rcount"}, 32'(Read_count), 32'(expReads));
    endtask

    // Pulses Init_start, then follows the fill; resetAt > 0 asserts reset in that busy cycle
    task automatic runFill(input int resetAt);
        int guard;
        Init_start = 1'b1;
        applyStimulus(18'd0, 16'd0, 1'b1);
        checkOutput("fill_busy_rise", 32'(Init_busy), 32'd1);
        modelFilling = 1'b1;
        busyCount    = 0;
        guard        = 0;
        while (Init_busy === 1'b1 && guard < 2000) begin
            busyCount++;
            guard++;
            Init_start = 1'b0;
            if (busyCount == 10) begin
                checkOutput("fill_pipe_init", 32'(SRAM_read_data), 32'h0000A5A5);
            end
            if (resetAt > 0 && busyCount == resetAt) begin
                doReset();
                break;
            end
            if (busyCount == 300) begin
                Init_start = 1'b1;
                applyStimulus(18'd10, 16'h1111, 1'b0);
            end else begin
                applyStimulus(18'd3, 16'h0000, 1'b1);
            end
        end
        Init_start   = 1'b0;
        modelFilling = 1'b0;
    endtask

    initial begin
        Resetn          = 1'b0;
        SRAM_address    = '0;
        SRAM_write_data = '0;
        SRAM_we_n       = 1'b1;
        Init_start      = 1'b0;
        Fault_enable    = 1'b0;
        Fault_address   = '0;
        Fault_bit       = '0;
        Fault_value     = 1'b0;

        doReset();
        checkOutput("rst_rdata", 32'(SRAM_read_data), 32'h0);
        checkOutput("rst_busy", 32'(Init_busy), 32'h0);
        checkOutput("rst_oor", 32'(Out_of_range), 32'h0);
        checkCounters("rst");

        for (int i = 0; i < 1024; i++) begin
            applyStimulus(18'(i), 16'(i), 1'b0);
        end
        for (int i = 0; i <= 1024; i++) begin
            applyStimulus((i < 1024) ? 18'(i) : 18'd0, 16'd0, 1'b1);
            if (i >= 1) begin
                checkOutput("readback", 32'(SRAM_read_data), 32'(i - 1));
            end
            if (i == 1023) begin
                checkOutput("readback_wcount", 32'(Write_count), 32'd1024);
                checkOutput("readback_rcount", 32'(Read_count), 32'd1024);
                checkOutput("readback_oor", 32'(Out_of_range), 32'h0);
            end
        end

        // Fault on address 5, bit 3 stuck at 1, then bit 0 stuck at 0
        Fault_address = 18'd5;
        Fault_bit     = 4'd3;
        Fault_value   = 1'b1;
        Fault_enable  = 1'b1;
        applyStimulus(18'd5, 16'd0, 1'b1);
        applyStimulus(18'd4, 16'd0, 1'b1);
        checkOutput("fault_hit", 32'(SRAM_read_data), 32'h000D);
        Fault_enable = 1'b0;
        applyStimulus(18'd5, 16'd0, 1'b1);
        checkOutput("fault_other_addr", 32'(SRAM_read_data), 32'h0004);
        Fault_enable = 1'b1;
        Fault_bit    = 4'd0;
        Fault_value  = 1'b0;
        applyStimulus(18'd5, 16'd0, 1'b1);
        checkOutput("fault_disabled", 32'(SRAM_read_data), 32'h0005);
        Fault_enable = 1'b0;
        applyStimulus(18'd5, 16'd0, 1'b1);
        checkOutput("fault_stuck0", 32'(SRAM_read_data), 32'h0004);
        applyStimulus(18'd0, 16'd0, 1'b1);
        checkOutput("fault_stored_intact", 32'(SRAM_read_data), 32'h0005);

        applyStimulus(18'd7, 16'hBEEF, 1'b0);
        applyStimulus(18'd7, 16'h0000, 1'b1);
        checkOutput("write_through", 32'(SRAM_read_data), 32'h0000BEEF);
        applyStimulus(18'd7, 16'h0000, 1'b1);
        checkOutput("read_after_write", 32'(SRAM_read_data), 32'h0000BEEF);
        applyStimulus(18'd0, 16'h0000, 1'b1);
        checkOutput("read_after_write2", 32'(SRAM_read_data), 32'h0000BEEF);

        // 18'h3FFFF shares its low ten bits with 1023, so aliasing would corrupt word 1023
        applyStimulus(18'h3FFFF, 16'h1234, 1'b0);
        checkOutput("oor_set", 32'(Out_of_range), 32'h1);
        applyStimulus(18'h3FFFF, 16'h0000, 1'b1);
        applyStimulus(18'd1024, 16'h0000, 1'b1);
        checkOutput("oor_read_top", 32'(SRAM_read_data), 32'h0);
        applyStimulus(18'd1023, 16'h0000, 1'b1);
        checkOutput("oor_read_depth", 32'(SRAM_read_data), 32'h0);
        applyStimulus(18'd0, 16'h0000, 1'b1);
        checkOutput("oor_no_alias", 32'(SRAM_read_data), 32'h03FF);
        checkCounters("oor");

        runFill(0);
        checkOutput("fill_length", 32'(busyCount), 32'd1024);
        checkOutput("fill_busy_fall", 32'(Init_busy), 32'h0);
        checkCounters("fill");
        checkOutput("oor_sticky", 32'(Out_of_range), 32'h1);
        for (int i = 0; i <= 1024; i++) begin
            applyStimulus((i < 1024) ? 18'(i) : 18'd0, 16'd0, 1'b1);
            if (i >= 1) begin
                checkOutput("fill_readback", 32'(SRAM_read_data), 32'h0000A5A5);
            end
        end

        runFill(500);
        checkOutput("midfill_rst_busy", 32'(Init_busy), 32'h0);
        checkOutput("midfill_rst_rdata", 32'(SRAM_read_data), 32'h0);
        checkOutput("midfill_rst_oor", 32'(Out_of_range), 32'h0);
        checkOutput("midfill_rst_wcount", 32'(Write_count), 32'h0);
        checkOutput("midfill_rst_rcount", 32'(Read_count), 32'h0);

        applyStimulus(18'd0, 16'h1111, 1'b0);
        applyStimulus(18'd1023, 16'h2222, 1'b0);
        runFill(0);
        checkOutput("refill_length", 32'(busyCount), 32'd1024);
        applyStimulus(18'd0, 16'd0, 1'b1);
        applyStimulus(18'd1023, 16'd0, 1'b1);
        applyStimulus(18'd0, 16'd0, 1'b1);
        checkOutput("refill_first", 32'(SRAM_read_data), 32'h0000A5A5);
        applyStimulus(18'd0, 16'd0, 1'b1);
        checkOutput("refill_last", 32'(SRAM_read_data), 32'h0000A5A5);
        checkCounters("refill");

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
